// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control unit
//
// Purpose : opcode/funct constants, state and instruction-class enums,
//           datapath select encodings and the per-class select table.
// Ports   : none (package).
package multi_cycle_ctrl_pkg;

   // Opcode / funct values of the supported instructions
   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;

   // RF write data source
   localparam logic [1:0] WD_ALU   = 2'b00;
   localparam logic [1:0] WD_DM    = 2'b01;
   localparam logic [1:0] WD_PC4   = 2'b10;
   // Next-PC source
   localparam logic [1:0] NPC_PC4  = 2'b00;
   localparam logic [1:0] NPC_BR   = 2'b01;
   localparam logic [1:0] NPC_JUMP = 2'b10;
   // ALU operation
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_OR   = 2'b10;
   // Destination register
   localparam logic [1:0] GPR_RD   = 2'b00;
   localparam logic [1:0] GPR_RT   = 2'b01;
   localparam logic [1:0] GPR_RA   = 2'b10;
   // Immediate extender mode
   localparam logic [1:0] EXT_NONE = 2'b00;
   localparam logic [1:0] EXT_IMM  = 2'b01;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXE    = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWR  = 4'd5,
      S_WB     = 4'd6,
      S_BRANCH = 4'd7,
      S_JUMP   = 4'd8,
      S_ILL    = 4'd9
   } state_t;

   typedef enum logic [2:0] {
      IC_ADDU,
      IC_SUBU,
      IC_ORI,
      IC_LW,
      IC_SW,
      IC_BEQ,
      IC_JAL,
      IC_ILLEGAL
   } instr_class_t;

   typedef struct packed {
      logic       bsel;
      logic [1:0] wdsel;
      logic [1:0] extop;
      logic [1:0] aluop;
      logic [1:0] gprsel;
   } sel_t;

   // Selects an instruction keeps for its whole post-decode lifetime
   function automatic sel_t class_sels(input instr_class_t c);
      sel_t s;
      s = '{bsel: 1'b0, wdsel: WD_ALU, extop: EXT_NONE, aluop: ALU_ADD, gprsel: GPR_RD};
      case (c)
         IC_ADDU: s.aluop = ALU_ADD;
         IC_SUBU: s.aluop = ALU_SUB;
         IC_ORI: begin
            s.aluop  = ALU_OR;
            s.bsel   = 1'b1;
            s.extop  = EXT_IMM;
            s.gprsel = GPR_RT;
         end
         IC_LW: begin
            s.bsel   = 1'b1;
            s.extop  = EXT_IMM;
            s.wdsel  = WD_DM;
            s.gprsel = GPR_RT;
         end
         IC_SW: begin
            s.bsel   = 1'b1;
            s.extop  = EXT_IMM;
         end
         IC_BEQ: begin
            s.aluop  = ALU_SUB;
            s.extop  = EXT_IMM;
         end
         IC_JAL: begin
            s.wdsel  = WD_PC4;
            s.gprsel = GPR_RA;
         end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// rtl/multi_cycle_ctrl_if.sv - IR/datapath-facing bundle of the multi-cycle control unit
//
// Purpose : groups the instruction fields, datapath status and all control
//           outputs of multi_cycle_ctrl.
// Signals : OP, Funct, Zero, MemRdy (to controller);
//           PCWr, IRWr, RFWr, DMWr, BSel, WDSel, NPCOp, EXTOp, ALUOp, GPRSel,
//           State, IllegalInstr, InstrCnt (from controller).
// Modports: master = controller side, slave = datapath side.
interface multi_cycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       OP;
   logic [5:0]       Funct;
   logic             Zero;
   logic             MemRdy;
   logic             PCWr;
   logic             IRWr;
   logic             RFWr;
   logic             DMWr;
   logic             BSel;
   logic [1:0]       WDSel;
   logic [1:0]       NPCOp;
   logic [1:0]       EXTOp;
   logic [1:0]       ALUOp;
   logic [1:0]       GPRSel;
   logic [3:0]       State;
   logic             IllegalInstr;
   logic [CNT_W-1:0] InstrCnt;

   modport master (
      input  OP, Funct, Zero, MemRdy,
      output PCWr, IRWr, RFWr, DMWr, BSel, WDSel, NPCOp, EXTOp, ALUOp, GPRSel,
             State, IllegalInstr, InstrCnt
   );

   modport slave (
      output OP, Funct, Zero, MemRdy,
      input  PCWr, IRWr, RFWr, DMWr, BSel, WDSel, NPCOp, EXTOp, ALUOp, GPRSel,
             State, IllegalInstr, InstrCnt
   );
endinterface

// File: rtl/multi_cycle_ctrl_mc_decode.sv
// rtl/multi_cycle_ctrl_mc_decode.sv - opcode/funct to instruction-class decoder
//
// Purpose : purely combinational classification of an instruction.
// Ports   : i_op    in  6  opcode field
//           i_funct in  6  funct field
//           o_class out    instruction class (IC_ILLEGAL if unsupported)
module mc_decode
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [5:0]   i_op,
   input  logic [5:0]   i_funct,
   output instr_class_t o_class
);

   always_comb begin
      o_class = IC_ILLEGAL;
      case (i_op)
         OP_RTYPE: begin
            if (i_funct == FUNCT_ADDU)      o_class = IC_ADDU;
            else if (i_funct == FUNCT_SUBU) o_class = IC_SUBU;
            else                            o_class = IC_ILLEGAL;
         end
         OP_ORI:  o_class = IC_ORI;
         OP_LW:   o_class = IC_LW;
         OP_SW:   o_class = IC_SW;
         OP_BEQ:  o_class = IC_BEQ;
         OP_JAL:  o_class = IC_JAL;
         default: o_class = IC_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle control unit for the MIPS core
//
// Purpose : sequences FETCH, DECODE and an instruction-specific path over a
//           shared ALU and memory port, with memory ready handshake and
//           illegal-opcode trapping.
// Ports   : clk  in  clock
//           rst  in  synchronous reset, active-high
//           bus  multi_cycle_ctrl_if.master (IR fields, status, controls)
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   multi_cycle_ctrl_if.master    bus
);

   state_t           r_state;
   state_t           w_next_state;
   logic [5:0]       r_op_q;
   logic [5:0]       r_funct_q;
   logic [CNT_W-1:0] r_instr_cnt;

   logic [5:0]       w_dec_op;
   logic [5:0]       w_dec_funct;
   instr_class_t     w_class;
   sel_t             w_sel;
   logic             w_retire;

   // In DECODE the latches are not loaded yet, so the next state has to be
   // decided from the live IR fields; everywhere else the latched copy is used.
   assign w_dec_op    = (r_state == S_DECODE) ? bus.OP    : r_op_q;
   assign w_dec_funct = (r_state == S_DECODE) ? bus.Funct : r_funct_q;

   mc_decode u_decode (
      .i_op    (w_dec_op),
      .i_funct (w_dec_funct),
      .o_class (w_class)
   );

   assign w_sel = class_sels(w_class);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next_state;
   end

   // IR field latches and retired-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_q      <= '0;
         r_funct_q   <= '0;
         r_instr_cnt <= '0;
      end else begin
         if (r_state == S_DECODE) begin
            r_op_q    <= bus.OP;
            r_funct_q <= bus.Funct;
         end
         if (w_retire) r_instr_cnt <= r_instr_cnt + 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH:  w_next_state = S_DECODE;
         S_DECODE: begin
            case (w_class)
               IC_ADDU, IC_SUBU, IC_ORI: w_next_state = S_EXE;
               IC_LW, IC_SW:             w_next_state = S_MEMADR;
               IC_BEQ:                   w_next_state = S_BRANCH;
               IC_JAL:                   w_next_state = S_JUMP;
               default:                  w_next_state = S_ILL;
            endcase
         end
         S_EXE:    w_next_state = S_WB;
         S_MEMADR: w_next_state = (w_class == IC_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next_state = bus.MemRdy ? S_WB : S_MEMRD;
         S_MEMWR:  w_next_state = bus.MemRdy ? S_FETCH : S_MEMWR;
         S_WB, S_BRANCH, S_JUMP, S_ILL: w_next_state = S_FETCH;
         default:  w_next_state = S_FETCH;
      endcase
   end

   // Output decode; rst overrides everything so an aborted instruction
   // cannot produce a write in the reset cycle.
   always_comb begin
      bus.PCWr         = 1'b0;
      bus.IRWr         = 1'b0;
      bus.RFWr         = 1'b0;
      bus.DMWr         = 1'b0;
      bus.BSel         = 1'b0;
      bus.WDSel        = WD_ALU;
      bus.NPCOp        = NPC_PC4;
      bus.EXTOp        = EXT_NONE;
      bus.ALUOp        = ALU_ADD;
      bus.GPRSel       = GPR_RD;
      bus.IllegalInstr = 1'b0;
      w_retire         = 1'b0;
      if (!rst) begin
         // Selects track the latched instruction from EXE/MEMADR onward
         if (r_state != S_FETCH && r_state != S_DECODE && r_state != S_ILL) begin
            bus.BSel   = w_sel.bsel;
            bus.WDSel  = w_sel.wdsel;
            bus.EXTOp  = w_sel.extop;
            bus.ALUOp  = w_sel.aluop;
            bus.GPRSel = w_sel.gprsel;
         end
         case (r_state)
            S_FETCH: bus.IRWr = 1'b1;
            S_MEMWR: begin
               bus.DMWr = 1'b1;
               bus.PCWr = bus.MemRdy;
               w_retire = bus.MemRdy;
            end
            S_WB: begin
               bus.RFWr = 1'b1;
               bus.PCWr = 1'b1;
               w_retire = 1'b1;
            end
            S_BRANCH: begin
               bus.PCWr  = 1'b1;
               bus.NPCOp = bus.Zero ? NPC_BR : NPC_PC4;
               w_retire  = 1'b1;
            end
            S_JUMP: begin
               bus.RFWr  = 1'b1;
               bus.PCWr  = 1'b1;
               bus.NPCOp = NPC_JUMP;
               w_retire  = 1'b1;
            end
            S_ILL: begin
               bus.IllegalInstr = 1'b1;
               bus.PCWr         = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.State    = r_state;
   assign bus.InstrCnt = r_instr_cnt;

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle replacement for the single-cycle control unit of the MIPS core.
- Sequences one shared ALU and one shared memory port over several cycles per instruction: FETCH, DECODE, then an instruction-specific path.
- Supports addu, subu, ori, lw, sw, beq and jal, with a data-memory ready handshake and illegal-opcode trapping.
- Sits between the IR (OP/Funct) and the datapath, driving the same select and enable signals the datapath already consumes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- OP  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- MemRdy  in  1  data memory done this cycle (read data valid / write accepted).
- PCWr  out  1  PC write enable.
- IRWr  out  1  IR write enable.
- RFWr  out  1  register file write enable.
- DMWr  out  1  data memory write strobe.
- BSel  out  1  ALU B operand select: 0 = rt, 1 = ext imm.
- WDSel  out  2  RF write data: 00 = ALU, 01 = DM, 10 = PC+4.
- NPCOp  out  2  next PC: 00 = PC+4, 01 = branch, 10 = jump.
- EXTOp  out  2  extender mode: 01 for ori/lw/sw/beq, 00 otherwise.
- ALUOp  out  2  00 = add, 01 = sub, 10 = or.
- GPRSel  out  2  destination: 00 = rd, 01 = rt, 10 = $31.
- State  out  4  current state, for debug.
- IllegalInstr  out  1  one-cycle pulse on a trapped opcode.
- InstrCnt  out  CNT_W  retired instructions.

Behaviour:
- Reset:
  - On a rising clk edge with rst=1: State=FETCH, op/funct latches cleared, InstrCnt=0.
  - While rst=1, all enables (PCWr, IRWr, RFWr, DMWr) are forced to 0 combinationally; selects are 0; IllegalInstr=0.
  - Reset mid-instruction aborts it with no further writes.
- States (4-bit encoding): FETCH=0, DECODE=1, EXE=2, MEMADR=3, MEMRD=4, MEMWR=5, WB=6, BRANCH=7, JUMP=8, ILL=9.
- FETCH: IRWr=1. Next state DECODE.
- DECODE: latch OP/Funct into op_q/funct_q. Next state:
  - R-type with funct addu/subu, or ori -> EXE.
  - lw/sw -> MEMADR.
  - beq -> BRANCH.
  - jal -> JUMP.
  - anything else, including R-type with another funct -> ILL.
- Select hold rule: all selects decode from op_q/funct_q and are held constant from EXE/MEMADR through the final state of the instruction.
- EXE:
  - addu: ALUOp=00, BSel=0, GPRSel=00.
  - subu: ALUOp=01, BSel=0, GPRSel=00.
  - ori: ALUOp=10, BSel=1, EXTOp=01, GPRSel=01.
  - Next state WB.
- MEMADR: BSel=1, EXTOp=01, ALUOp=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: stay while MemRdy=0; on MemRdy=1 go to WB.
- MEMWR:
  - DMWr=1 held until MemRdy=1.
  - In the MemRdy=1 cycle: PCWr=1, NPCOp=00, InstrCnt+1, next state FETCH.
  - PCWr depends combinationally on MemRdy here.
- WB: RFWr=1, PCWr=1, NPCOp=00, InstrCnt+1, next state FETCH.
  - WDSel=01 for lw, 00 otherwise.
  - GPRSel per instruction.
- BRANCH: ALUOp=01, BSel=0, EXTOp=01, PCWr=1, NPCOp = Zero ? 01 : 00, InstrCnt+1, next state FETCH.
- JUMP: RFWr=1, WDSel=10, GPRSel=10, PCWr=1, NPCOp=10, InstrCnt+1, next state FETCH.
- ILL: IllegalInstr=1, PCWr=1, NPCOp=00 (skip the opcode), InstrCnt unchanged, next state FETCH.
- Default write enables: PCWr, IRWr, RFWr and DMWr are 0 in every state not listed above. At most one RFWr/DMWr pulse per instruction.
- InstrCnt wraps at 2^CNT_W without any flag.
- CPI: R-type/ori 4, lw 5+wait, sw 4+wait, beq 3, jal 3, illegal 3.

Decomposition:
- Shared define file: opcode/funct constants (existing instruction definitions), state encodings, WDSel/NPCOp/ALUOp/GPRSel/EXTOp encodings.
- Sub-module mc_decode: combinational op_q/funct_q -> instruction class (RTYPE_ADDU, RTYPE_SUBU, ORI, LW, SW, BEQ, JAL, ILLEGAL).
- Top module holds the state register, latches, counter and output decode.

Test Plan:
- Reset held 2 cycles, then released -> State=0, IRWr=1 in the first cycle, InstrCnt=0; PCWr/RFWr/DMWr=0 throughout reset.
- addu (OP=0, Funct=0x21) -> states 0,1,2,6; in WB: RFWr=1, WDSel=00, GPRSel=00, ALUOp=00, PCWr=1; InstrCnt=1.
- lw (OP=0x23), MemRdy low for 3 cycles -> MEMRD held 4 cycles; WB: WDSel=01, GPRSel=01, RFWr=1; no RFWr before WB.
- sw (OP=0x2B), MemRdy=1 on the second MEMWR cycle -> DMWr=1 for exactly 2 cycles; PCWr=1 only in the second cycle; next state FETCH.
- beq (OP=0x04) with Zero=1 -> NPCOp=01, PCWr=1; repeat with Zero=0 -> NPCOp=00. jal (OP=0x03) -> RFWr=1, WDSel=10, GPRSel=10, NPCOp=10.
- OP=0x3F -> ILL: IllegalInstr pulses 1 cycle, PCWr=1, NPCOp=00, InstrCnt unchanged. Separately, assert rst during MEMRD -> State=0 next edge with no RFWr.
